// File: rtl/neural_hw_seq_ctrl_if.sv
// Avalon-MM slave register bus for neural_hw_seq_ctrl.
// Signal names match the legacy port names.
interface neural_hw_seq_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/neural_hw_seq_ctrl.sv
// Layer sequencer for a neural-network datapath.
// It is started and acknowledged through a 2-bit PIO handshake, issues one
// layer_start pulse per layer, and exposes NUM_LAYERS/STATUS/TIMEOUT/CYCLES
// registers over Avalon-MM.
// Optional watchdog: define NEURAL_HW_SEQ_CTRL_TIMEOUT_EN.
module neural_hw_seq_ctrl #(
    parameter int unsigned LAYER_W            = 8,
    parameter int unsigned TIMEOUT_DEFAULT    = 32'd1000000,
    parameter int unsigned NUM_LAYERS_DEFAULT = 3
) (
    input  logic               clk,
    input  logic               reset,
    neural_hw_seq_ctrl_if.slave bus,
    input  logic [1:0]         to_hw_sig,
    output logic [1:0]         to_sw_sig,
    output logic               layer_start,
    output logic [LAYER_W-1:0] layer_idx,
    input  logic               layer_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_to_sw_sig;
    logic [1:0]         w_next_sw;
    logic [LAYER_W-1:0] r_layer_idx;
    logic [LAYER_W-1:0] r_num_layers;
    logic [31:0]        r_cycles;
    logic               w_wr;
    logic               w_busy;
    logic               w_last;
    logic               w_go;
    logic [7:0]         w_idx8;
    logic [31:0]        w_timeout_rd;
`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
    logic [31:0]        r_timeout;
    logic [31:0]        r_wd;
    logic               w_wd_expired;
`endif

    assign w_wr   = bus.chipselect && !bus.write_n && (r_state == S_IDLE);
    assign w_busy = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_NEXT);
    assign w_last = (r_layer_idx == r_num_layers - LAYER_W'(1));
    assign w_go   = (r_state == S_IDLE) && (to_hw_sig == 2'b01);
    assign w_idx8 = 8'(r_layer_idx);

    assign to_sw_sig   = r_to_sw_sig;
    assign layer_idx   = r_layer_idx;
    assign layer_start = (r_state == S_START) && (r_num_layers != '0);

`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
    assign w_wd_expired = (r_timeout != '0) && (r_wd >= r_timeout - 32'd1);
    assign w_timeout_rd = r_timeout;
`else
    assign w_timeout_rd = '0;
`endif

    // Next-state decode; layer_done is only honoured in WAIT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (to_hw_sig == 2'b01) w_next_state = S_START;
            S_START: w_next_state = (r_num_layers == '0) ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (layer_done) begin
                    w_next_state = S_NEXT;
                end
`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
                else if (w_wd_expired) begin
                    w_next_state = S_ERROR;
                end
`endif
            end
            S_NEXT:  w_next_state = w_last ? S_DONE : S_START;
            S_DONE,
            S_ERROR: if (to_hw_sig == 2'b10) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status code follows the next state so it is registered alongside it.
    always_comb begin
        case (w_next_state)
            S_START, S_WAIT, S_NEXT: w_next_sw = 2'b01;
            S_DONE:                  w_next_sw = 2'b10;
            S_ERROR:                 w_next_sw = 2'b11;
            default:                 w_next_sw = 2'b00;
        endcase
    end

    // State and PIO status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_to_sw_sig <= 2'b00;
        end else begin
            r_state     <= w_next_state;
            r_to_sw_sig <= w_next_sw;
        end
    end

    // Layer index: cleared on start, advanced on NEXT unless on the last layer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_layer_idx <= '0;
        end else if (w_go) begin
            r_layer_idx <= '0;
        end else if ((r_state == S_NEXT) && !w_last) begin
            r_layer_idx <= r_layer_idx + LAYER_W'(1);
        end
    end

    // Saturating busy-cycle counter, cleared on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_go) begin
            r_cycles <= '0;
        end else if (w_busy && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // NUM_LAYERS register, writable only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_layers <= LAYER_W'(NUM_LAYERS_DEFAULT);
        end else if (w_wr && (bus.address == 2'd0)) begin
            r_num_layers <= LAYER_W'(bus.writedata);
        end
    end

`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
    // TIMEOUT register, writable only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 32'(TIMEOUT_DEFAULT);
        end else if (w_wr && (bus.address == 2'd2)) begin
            r_timeout <= bus.writedata;
        end
    end

    // Watchdog counts completed WAIT cycles; held at zero outside WAIT so it is fresh on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd <= '0;
        end else if (r_wd != '1) begin
            r_wd <= r_wd + 32'd1;
        end
    end
`endif

    // Zero-wait-state combinational read mux.
    always_comb begin
        case (bus.address)
            2'd0:    bus.readdata = 32'(r_num_layers);
            2'd1:    bus.readdata = {16'h0000, w_idx8, 5'b00000, r_state};
            2'd2:    bus.readdata = w_timeout_rd;
            default: bus.readdata = r_cycles;
        endcase
    end

endmodule

// File: tb/tb_neural_hw_seq_ctrl.sv
// Self-checking bench for neural_hw_seq_ctrl.
// Watchdog checks are built when NEURAL_HW_SEQ_CTRL_TIMEOUT_EN is defined.
module tb_neural_hw_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    neural_hw_seq_ctrl_if bus();
    logic [1:0] to_hw_sig;
    logic [1:0] to_sw_sig;
    logic       layer_start;
    logic [7:0] layer_idx;
    logic       layer_done;

    neural_hw_seq_ctrl #(
        .LAYER_W(8),
        .TIMEOUT_DEFAULT(32'd1000000),
        .NUM_LAYERS_DEFAULT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .to_hw_sig(to_hw_sig),
        .to_sw_sig(to_sw_sig),
        .layer_start(layer_start),
        .layer_idx(layer_idx),
        .layer_done(layer_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    int idx_q[$];

    // Record every layer_start pulse and the index it carried.
    always @(negedge clk) begin
        if (!reset && layer_start) begin
            pulse_cnt++;
            idx_q.push_back(int'(layer_idx));
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #3000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // One full run: start, serve n layers with the given WAIT lengths, check DONE, hold start, ack.
    // Reference: CYCLES = sum(wait+2) (or 1 when no layers); indices 0..n-1; START-to-START = wait+2.
    task automatic run_seq(input int n, input int dly[$], input bit spur, input bit busy_wr);
        int exp_cycles;
        int since;
        int base;
        int w;
        logic [31:0] rd;
        exp_cycles = (n == 0) ? 1 : 0;
        for (int k = 0; k < n; k++) exp_cycles += dly[k] + 2;
        idx_q.delete();
        base  = pulse_cnt;
        since = 0;
        to_hw_sig = 2'b01;
        tick();
        to_hw_sig = 2'b00;
        check("start_busy", to_sw_sig, 2'b01);
        bus_read(2'd3, rd);
        check("cycles_cleared_on_start", rd, 0);
        if (n == 0) begin
            check("zero_layers_no_start", layer_start, 1'b0);
            tick();
        end
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!layer_start && w < 20) begin
                tick();
                w++;
                since++;
            end
            check("layer_start_seen", layer_start, 1'b1);
            check("layer_idx", layer_idx, k);
            check("busy_during_start", to_sw_sig, 2'b01);
            if (k > 0) check("start_to_start", since, dly[k-1] + 2);
            since = 0;
            layer_done = spur;
            tick();
            since++;
            for (int j = 1; j <= dly[k]; j++) begin
                layer_done = (j == dly[k]);
                if (busy_wr && k == 0 && j == 1) begin
                    bus.address    = 2'd0;
                    bus.writedata  = 32'd7;
                    bus.chipselect = 1'b1;
                    bus.write_n    = 1'b0;
                end
                tick();
                since++;
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b1;
            end
            layer_done = 1'b0;
        end
        if (n > 0) tick();
        check("done_status", to_sw_sig, 2'b10);
        check("done_idx_held", layer_idx, (n == 0) ? 0 : n - 1);
        bus_read(2'd3, rd);
        check("cycles_total", rd, exp_cycles);
        bus_read(2'd1, rd);
        check("status_done_code", rd[2:0], 3'd4);
        check("pulse_count", pulse_cnt - base, n);
        for (int k = 0; k < n; k++) begin
            check("pulse_idx_seq", (k < idx_q.size()) ? idx_q[k] : -1, k);
        end
        if (busy_wr) begin
            bus_read(2'd0, rd);
            check("busy_write_ignored", rd, n);
        end
        to_hw_sig = 2'b01;
        tick();
        tick();
        check("hold_start_in_done", to_sw_sig, 2'b10);
        check("no_restart_without_ack", pulse_cnt - base, n);
        bus_read(2'd3, rd);
        check("cycles_held_in_done", rd, exp_cycles);
        to_hw_sig = 2'b10;
        tick();
        to_hw_sig = 2'b00;
        check("ack_to_idle", to_sw_sig, 2'b00);
        bus_read(2'd1, rd);
        check("status_idle_code", rd[2:0], 3'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int dq[$];
        int n;
        int base;
        reset          = 1'b1;
        to_hw_sig      = 2'b00;
        layer_done     = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick();
        tick();

        // Reset values.
        check("rst_to_sw_sig", to_sw_sig, 2'b00);
        check("rst_layer_start", layer_start, 1'b0);
        check("rst_layer_idx", layer_idx, 0);
        bus_read(2'd0, rd);
        check("rst_num_layers", rd, 3);
        bus_read(2'd1, rd);
        check("rst_status", rd, 0);
        bus_read(2'd3, rd);
        check("rst_cycles", rd, 0);
        bus_read(2'd2, rd);
`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
        check("rst_timeout", rd, 32'd1000000);
`else
        check("rst_timeout_absent", rd, 0);
`endif
        reset = 1'b0;
        tick();

        // Register-write rules in IDLE.
        bus_write(2'd2, 32'd12345);
        bus_read(2'd2, rd);
`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
        check("timeout_write", rd, 32'd12345);
`else
        check("timeout_write_ignored", rd, 0);
`endif
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_read(2'd3, rd);
        check("cycles_ro", rd, 0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd);
        check("status_ro", rd, 0);
        check("idle_after_ro_writes", to_sw_sig, 2'b00);

        // Three layers, done 5 cycles after each start; write of 7 while busy is dropped.
        dq = {5, 5, 5};
        run_seq(3, dq, 1'b0, 1'b1);
        bus_read(2'd3, rd);
        check("three_layer_cycles_21", rd, 21);
        bus_write(2'd0, 32'd7);
        bus_read(2'd0, rd);
        check("idle_write_num_layers", rd, 7);

        // Zero layers.
        bus_write(2'd0, 32'd0);
        dq = {};
        run_seq(0, dq, 1'b0, 1'b0);

        // Randomized runs, including layer_done raised alongside layer_start.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 4);
            dq = {};
            for (int k = 0; k < n; k++) dq.push_back($urandom_range(1, 6));
            bus_write(2'd0, n);
            bus_read(2'd0, rd);
            check("rand_num_layers", rd, n);
            run_seq(n, dq, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during WAIT of layer 1.
        bus_write(2'd0, 32'd2);
        to_hw_sig = 2'b01;
        tick();
        to_hw_sig = 2'b00;
        check("abort_l0_start", layer_start, 1'b1);
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        tick();
        check("abort_l1_start", layer_start, 1'b1);
        check("abort_l1_idx", layer_idx, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_to_sw_sig", to_sw_sig, 2'b00);
        check("abort_layer_idx", layer_idx, 0);
        check("abort_layer_start", layer_start, 1'b0);
        bus_read(2'd0, rd);
        check("abort_num_layers", rd, 3);
        bus_read(2'd3, rd);
        check("abort_cycles", rd, 0);
        base = pulse_cnt;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("no_start_after_reset", pulse_cnt - base, 0);
        check("idle_after_reset", to_sw_sig, 2'b00);
        dq = {2, 1, 3};
        run_seq(3, dq, 1'b1, 1'b0);

`ifdef NEURAL_HW_SEQ_CTRL_TIMEOUT_EN
        // Watchdog: TIMEOUT=10, layer_done never arrives.
        bus_write(2'd2, 32'd10);
        bus_write(2'd0, 32'd1);
        to_hw_sig = 2'b01;
        tick();
        to_hw_sig = 2'b00;
        check("wd_start", layer_start, 1'b1);
        repeat (10) tick();
        check("wd_busy_at_10_waits", to_sw_sig, 2'b01);
        tick();
        check("wd_error", to_sw_sig, 2'b11);
        bus_read(2'd1, rd);
        check("wd_status_code", rd[2:0], 3'd5);
        to_hw_sig = 2'b01;
        tick();
        check("wd_error_holds", to_sw_sig, 2'b11);
        to_hw_sig = 2'b10;
        tick();
        to_hw_sig = 2'b00;
        check("wd_ack_idle", to_sw_sig, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
